// File: rtl/slave_rx_flit_decoder.sv
// Receive-side flit decoder: turns the 40-bit header/address/data flit stream
// back into registered per-field outputs with one-cycle valid pulses.
module slave_rx_flit_decoder #(
  parameter int unsigned DATA_LINE_WIDTH = 40,
  parameter int unsigned WORD_SIZE       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_LINE_WIDTH-1:0] i_flit,
  input  logic                       i_flit_valid,
  output logic                       o_flit_ready,
  input  logic                       i_slave_rx_ready,
  output logic [2:0]                 o_slave_rx_cmd,
  output logic                       o_slave_rx_cmd_valid,
  output logic [2:0]                 o_slave_rx_length,
  output logic                       o_slave_rx_length_valid,
  output logic [WORD_SIZE-1:0]       o_slave_rx_addr,
  output logic                       o_slave_rx_addr_valid,
  output logic [5:0]                 o_slave_rx_feature0,
  output logic                       o_slave_rx_feature0_valid,
  output logic [5:0]                 o_slave_rx_feature1,
  output logic                       o_slave_rx_feature1_valid,
  output logic [WORD_SIZE-1:0]       o_slave_rx_data,
  output logic                       o_slave_rx_data_valid,
  output logic                       o_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [2:0] CMD_RD_REQ = 3'd0;
  localparam logic [2:0] CMD_WR_REQ = 3'd1;
  localparam logic [2:0] CMD_RD_RSP = 3'd2;
  localparam logic [2:0] LEN_MAX    = 3'd5;

  logic [1:0]           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [2:0]           cmd_d, len_d;
  logic [WORD_SIZE-1:0] addr_d, data_d;
  logic [5:0]           f0_d, f1_d;
  logic                 cmd_v_d, len_v_d, addr_v_d, f0_v_d, f1_v_d, data_v_d, err_d;

  logic                 accept;
  logic                 hdr_mode, hdr_valid;
  logic [2:0]           hdr_cmd, hdr_len;
  logic [4:0]           hdr_cnt;

  assign o_flit_ready = i_slave_rx_ready && !rst;
  assign accept       = i_flit_valid && o_flit_ready;

  assign hdr_mode  = i_flit[0];
  assign hdr_valid = i_flit[1];
  assign hdr_cmd   = i_flit[4:2];
  assign hdr_len   = i_flit[7:5];
  // Only meaningful for length <= 5; longer codes are rejected before use.
  assign hdr_cnt   = 5'((6'd1 << hdr_len) - 6'd1);

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = o_slave_rx_cmd;
    len_d    = o_slave_rx_length;
    addr_d   = o_slave_rx_addr;
    f0_d     = o_slave_rx_feature0;
    f1_d     = o_slave_rx_feature1;
    data_d   = o_slave_rx_data;
    cmd_v_d  = 1'b0;
    len_v_d  = 1'b0;
    addr_v_d = 1'b0;
    f0_v_d   = 1'b0;
    f1_v_d   = 1'b0;
    data_v_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && hdr_valid) begin
          if (hdr_cmd > CMD_RD_RSP || hdr_len > LEN_MAX) begin
            err_d = 1'b1;
          end else begin
            cmd_d   = hdr_cmd;
            len_d   = hdr_len;
            cmd_v_d = 1'b1;
            len_v_d = 1'b1;
            cnt_d   = hdr_cnt;
            if (hdr_mode) begin
              f0_d   = i_flit[13:8];
              f1_d   = i_flit[19:14];
              f0_v_d = 1'b1;
              f1_v_d = 1'b1;
            end else if (hdr_cmd != CMD_RD_RSP) begin
              addr_d   = i_flit[8 +: WORD_SIZE];
              addr_v_d = 1'b1;
            end
            if (hdr_mode && hdr_cmd != CMD_RD_RSP) begin
              state_d = ST_ADDR;
            end else if (hdr_cmd != CMD_RD_REQ) begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_ADDR: begin
        if (accept) begin
          addr_d   = i_flit[WORD_SIZE-1:0];
          addr_v_d = 1'b1;
          state_d  = (o_slave_rx_cmd == CMD_WR_REQ) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        // Terminal check precedes the decrement, so the counter never wraps.
        if (accept) begin
          data_d   = i_flit[WORD_SIZE-1:0];
          data_v_d = 1'b1;
          if (cnt_q == 5'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                   <= ST_IDLE;
      cnt_q                     <= 5'd0;
      o_slave_rx_cmd            <= 3'd0;
      o_slave_rx_cmd_valid      <= 1'b0;
      o_slave_rx_length         <= 3'd0;
      o_slave_rx_length_valid   <= 1'b0;
      o_slave_rx_addr           <= '0;
      o_slave_rx_addr_valid     <= 1'b0;
      o_slave_rx_feature0       <= 6'd0;
      o_slave_rx_feature0_valid <= 1'b0;
      o_slave_rx_feature1       <= 6'd0;
      o_slave_rx_feature1_valid <= 1'b0;
      o_slave_rx_data           <= '0;
      o_slave_rx_data_valid     <= 1'b0;
      o_err                     <= 1'b0;
    end else begin
      state_q                   <= state_d;
      cnt_q                     <= cnt_d;
      o_slave_rx_cmd            <= cmd_d;
      o_slave_rx_cmd_valid      <= cmd_v_d;
      o_slave_rx_length         <= len_d;
      o_slave_rx_length_valid   <= len_v_d;
      o_slave_rx_addr           <= addr_d;
      o_slave_rx_addr_valid     <= addr_v_d;
      o_slave_rx_feature0       <= f0_d;
      o_slave_rx_feature0_valid <= f0_v_d;
      o_slave_rx_feature1       <= f1_d;
      o_slave_rx_feature1_valid <= f1_v_d;
      o_slave_rx_data           <= data_d;
      o_slave_rx_data_valid     <= data_v_d;
      o_err                     <= err_d;
    end
  end

endmodule

// File: tb/tb_slave_rx_flit_decoder.sv
// Scoreboard bench for slave_rx_flit_decoder: each scenario queues the pulses
// it expects, a negedge monitor pops and compares them as the DUT emits them.
module tb_slave_rx_flit_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] i_flit;
  logic        i_flit_valid;
  logic        o_flit_ready;
  logic        i_slave_rx_ready;
  logic [2:0]  cmd, len;
  logic        cmd_v, len_v, addr_v, f0_v, f1_v, data_v, err;
  logic [31:0] addr, data;
  logic [5:0]  f0, f1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        err, cmd_v, len_v, addr_v, f0_v, f1_v, data_v;
    logic [2:0]  cmd, len;
    logic [31:0] addr, data;
    logic [5:0]  f0, f1;
  } exp_t;

  exp_t sb[$];

  slave_rx_flit_decoder #(.DATA_LINE_WIDTH(40), .WORD_SIZE(32)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .i_flit                    (i_flit),
    .i_flit_valid              (i_flit_valid),
    .o_flit_ready              (o_flit_ready),
    .i_slave_rx_ready          (i_slave_rx_ready),
    .o_slave_rx_cmd            (cmd),
    .o_slave_rx_cmd_valid      (cmd_v),
    .o_slave_rx_length         (len),
    .o_slave_rx_length_valid   (len_v),
    .o_slave_rx_addr           (addr),
    .o_slave_rx_addr_valid     (addr_v),
    .o_slave_rx_feature0       (f0),
    .o_slave_rx_feature0_valid (f0_v),
    .o_slave_rx_feature1       (f1),
    .o_slave_rx_feature1_valid (f1_v),
    .o_slave_rx_data           (data),
    .o_slave_rx_data_valid     (data_v),
    .o_err                     (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t e_none();
    exp_t e;
    e.err = 0; e.cmd_v = 0; e.len_v = 0; e.addr_v = 0;
    e.f0_v = 0; e.f1_v = 0; e.data_v = 0;
    e.cmd = 0; e.len = 0; e.addr = 0; e.data = 0; e.f0 = 0; e.f1 = 0;
    return e;
  endfunction

  function automatic exp_t e_hdr(input logic [2:0] c, input logic [2:0] l,
                                 input logic av, input logic [31:0] a,
                                 input logic fv, input logic [5:0] x0,
                                 input logic [5:0] x1);
    exp_t e = e_none();
    e.cmd_v = 1; e.len_v = 1; e.cmd = c; e.len = l;
    e.addr_v = av; e.addr = a;
    e.f0_v = fv; e.f1_v = fv; e.f0 = x0; e.f1 = x1;
    return e;
  endfunction

  function automatic exp_t e_addr(input logic [31:0] a);
    exp_t e = e_none();
    e.addr_v = 1; e.addr = a;
    return e;
  endfunction

  function automatic exp_t e_data(input logic [31:0] d);
    exp_t e = e_none();
    e.data_v = 1; e.data = d;
    return e;
  endfunction

  function automatic exp_t e_err();
    exp_t e = e_none();
    e.err = 1;
    return e;
  endfunction

  // Scoreboard monitor: any cycle with a pulse must match the queue head
  always @(negedge clk) begin
    if (err === 1'b1 || cmd_v === 1'b1 || len_v === 1'b1 || addr_v === 1'b1 ||
        f0_v === 1'b1 || f1_v === 1'b1 || data_v === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse t=%0t err=%b cmd_v=%b len_v=%b addr_v=%b f_v=%b%b data_v=%b",
                 $time, err, cmd_v, len_v, addr_v, f0_v, f1_v, data_v);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({err, cmd_v, len_v, addr_v, f0_v, f1_v, data_v} !==
              {e.err, e.cmd_v, e.len_v, e.addr_v, e.f0_v, e.f1_v, e.data_v} ||
            (e.cmd_v && (cmd !== e.cmd || len !== e.len)) ||
            (e.addr_v && addr !== e.addr) ||
            (e.f0_v && (f0 !== e.f0 || f1 !== e.f1)) ||
            (e.data_v && data !== e.data)) begin
          failures++;
          $display("FAIL scoreboard t=%0t got v=%b cmd=%0d len=%0d addr=%h f=%h/%h data=%h exp v=%b cmd=%0d len=%0d addr=%h f=%h/%h data=%h",
                   $time, {err, cmd_v, len_v, addr_v, f0_v, f1_v, data_v},
                   cmd, len, addr, f0, f1, data,
                   {e.err, e.cmd_v, e.len_v, e.addr_v, e.f0_v, e.f1_v, e.data_v},
                   e.cmd, e.len, e.addr, e.f0, e.f1, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a flit and return just after the edge that accepts it
  task automatic drive(input logic [39:0] f);
    i_flit = f;
    i_flit_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [39:0] f, input exp_t e);
    sb.push_back(e);
    drive(f);
  endtask

  task automatic idle(input int n);
    i_flit_valid = 1'b0;
    i_flit = 40'h0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_flit = 40'h0; i_flit_valid = 1'b0; i_slave_rx_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({cmd, len, addr, f0, f1, data, cmd_v, len_v, addr_v, f0_v, f1_v, data_v, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got cmd=%0d addr=%h data=%h err=%b exp all zero", cmd, addr, data, err);
    end
    checks++;
    if (o_flit_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b exp 0", o_flit_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_flit_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b exp 1", o_flit_ready);
    end
    idle(1);
  endtask

  task automatic test_lw_write();
    send(40'hFFDD000026, e_hdr(3'd1, 3'd1, 1'b1, 32'hFFDD0000, 1'b0, 6'd0, 6'd0));
    checks++;
    if (cmd_v !== 1'b1 || addr !== 32'hFFDD0000) begin
      failures++;
      $display("FAIL lw_hdr_latency got cmd_v=%b addr=%h exp 1 ffdd0000", cmd_v, addr);
    end
    send(40'h00000000AA, e_data(32'h000000AA));
    send(40'h00000000BB, e_data(32'h000000BB));
    idle(2);
    checks++;
    if (addr !== 32'hFFDD0000 || data !== 32'h000000BB) begin
      failures++;
      $display("FAIL lw_hold got addr=%h data=%h exp ffdd0000 000000bb", addr, data);
    end
  endtask

  task automatic ext_write();
    send(40'h00000FC147, e_hdr(3'd1, 3'd2, 1'b0, 32'h0, 1'b1, 6'h01, 6'h3F));
    send(40'h0000000888, e_addr(32'h00000888));
    send(40'h0000001234, e_data(32'h00001234));
    send(40'h0000005678, e_data(32'h00005678));
    send(40'h0000002444, e_data(32'h00002444));
    send(40'h0000003666, e_data(32'h00003666));
  endtask

  task automatic test_ext_write();
    ext_write();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL ext_write_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    send(40'hAABB000022, e_hdr(3'd0, 3'd1, 1'b1, 32'hAABB0000, 1'b0, 6'd0, 6'd0));
    ext_write();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_read_resp();
    drive(40'h0);
    send(40'h000000004B, e_hdr(3'd2, 3'd2, 1'b0, 32'h0, 1'b1, 6'd0, 6'd0));
    for (int i = 0; i < 4; i++)
      send(40'hFF00000000 | 40'(32'hC0DE0000 + 32'(i)), e_data(32'hC0DE0000 + 32'(i)));
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL read_resp_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_max_length();
    send(40'h12345678AA, e_hdr(3'd2, 3'd5, 1'b0, 32'h0, 1'b0, 6'd0, 6'd0));
    for (int i = 0; i < 32; i++)
      send(40'(32'h00A50000 + 32'(i)), e_data(32'h00A50000 + 32'(i)));
    send(40'h0102030422, e_hdr(3'd0, 3'd1, 1'b1, 32'h01020304, 1'b0, 6'd0, 6'd0));
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL max_length_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_error();
    send(40'h000000001E, e_err());
    checks++;
    if (err !== 1'b1 || cmd_v !== 1'b0) begin
      failures++;
      $display("FAIL err_cmd got err=%b cmd_v=%b exp 1 0", err, cmd_v);
    end
    idle(1);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_one_cycle got %b exp 0", err);
    end
    send(40'h00000000C6, e_err());
    send(40'hFFDD000026, e_hdr(3'd1, 3'd1, 1'b1, 32'hFFDD0000, 1'b0, 6'd0, 6'd0));
    send(40'h0000000001, e_data(32'h1));
    send(40'h0000000002, e_data(32'h2));
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL error_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    send(40'h000000004B, e_hdr(3'd2, 3'd2, 1'b0, 32'h0, 1'b1, 6'd0, 6'd0));
    send(40'h0000000011, e_data(32'h11));
    i_flit = 40'h0000000022;
    i_flit_valid = 1'b1;
    i_slave_rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_flit_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready cycle=%0d got %b exp 0", i, o_flit_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (data_v !== 1'b0 || data !== 32'h11) begin
        failures++;
        $display("FAIL bp_stall cycle=%0d got data_v=%b data=%h exp 0 00000011", i, data_v, data);
      end
    end
    i_slave_rx_ready = 1'b1;
    send(40'h0000000022, e_data(32'h22));
    send(40'h0000000033, e_data(32'h33));
    send(40'h0000000044, e_data(32'h44));
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL bp_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    send(40'h00000FC147, e_hdr(3'd1, 3'd2, 1'b0, 32'h0, 1'b1, 6'h01, 6'h3F));
    send(40'h0000000888, e_addr(32'h00000888));
    rst = 1'b1;
    i_flit_valid = 1'b0;
    #1;
    checks++;
    if (o_flit_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_ready got %b exp 0", o_flit_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({cmd, len, addr, f0, f1, data, cmd_v, len_v, addr_v, f0_v, f1_v, data_v, err} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got cmd=%0d addr=%h f0=%h data=%h exp all zero", cmd, addr, f0, data);
    end
    rst = 1'b0;
    send(40'hFFDD000026, e_hdr(3'd1, 3'd1, 1'b1, 32'hFFDD0000, 1'b0, 6'd0, 6'd0));
    send(40'h00000000AA, e_data(32'hAA));
    send(40'h00000000BB, e_data(32'hBB));
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_drain got %0d pending exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_lw_write();
    test_ext_write();
    test_back_to_back();
    test_read_resp();
    test_max_length();
    test_error();
    test_backpressure();
    test_reset_mid_packet();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slave_rx_flit_decoder.md
# slave_rx_flit_decoder

Receive-side flit decoder for the chiplet link. It consumes the 40-bit flit stream produced by the master TX FSM, after link and FIFO transit, and decodes it back into per-field outputs: command, address, length, feature0/1 and data words. These outputs feed the slave-side consumer. It is the inverse of the TX packetizer: one header flit, an optional address flit, then 1–32 data flits.

## Interface
Parameters:
- DATA_LINE_WIDTH, 40, flit width; fixed at 40 for this format.
- WORD_SIZE, 32, width of address and data fields.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- i_flit  in  DATA_LINE_WIDTH  incoming flit.
- i_flit_valid  in  1  i_flit is valid this cycle.
- o_flit_ready  out  1  decoder accepts a flit this cycle.
- i_slave_rx_ready  in  1  downstream consumer can take decoded fields.
- o_slave_rx_cmd / o_slave_rx_cmd_valid  out  3 / 1  decoded command.
- o_slave_rx_length / o_slave_rx_length_valid  out  3 / 1  decoded length code.
- o_slave_rx_addr / o_slave_rx_addr_valid  out  WORD_SIZE / 1  request address.
- o_slave_rx_feature0 / o_slave_rx_feature0_valid  out  6 / 1  extended feature0.
- o_slave_rx_feature1 / o_slave_rx_feature1_valid  out  6 / 1  extended feature1.
- o_slave_rx_data / o_slave_rx_data_valid  out  WORD_SIZE / 1  one data word.
- o_err  out  1  one-cycle pulse when a header is rejected.

## Operation
Header flit fields:
- [0] mode: 0 = lightweight, 1 = extended.
- [1] valid.
- [4:2] cmd: 000 = read request, 001 = write request, 010 = read response.
- [7:5] length: 0..5, meaning 4B..128B.
- Lightweight: [39:8] is the address.
- Extended: [13:8] is feature0, [19:14] is feature1, [39:20] is reserved and ignored.

Flit sequence per packet:
- Lightweight: header, then data.
- Extended read or write request: header, then address flit (address in [31:0]), then data.
- Read response, either mode: header, then data. No address is carried; a lightweight response header's [39:8] is ignored.

Data flits:
- Write requests and read responses carry N = 1 << length data flits. The data word is in [31:0]; [39:32] is ignored.
- Read requests carry no data flits.

Handshake:
- A flit transfers when i_flit_valid && o_flit_ready.
- o_flit_ready = i_slave_rx_ready && !rst. The decoder never stalls internally.

State machine:
- IDLE: waiting for a header.
  - A header with [1] = 0 is an idle flit (e.g. 40'h0). It is dropped silently.
  - A header with cmd > 010 or length > 5 is dropped, pulses o_err, and stays in IDLE.
  - A good header latches cmd and length and loads the word counter with N-1.
  - From a good header: extended request goes to ADDR. Otherwise, if the packet has data, go to DATA. Otherwise stay in IDLE (lightweight read request).
- ADDR: one flit. Then go to DATA for a write, or IDLE for a read.
- DATA: each accepted flit emits one word. The counter decrements; on the flit accepted with counter = 0, return to IDLE.

Word counter:
- 5 bits, loaded with (1 << length) - 1, so 0..31.
- It never wraps, because the terminal check happens before the decrement.

Field outputs:
- Field data registers update only on an accepted flit. Values hold between pulses.
- Each *_valid is a one-cycle pulse.
  - cmd_valid and length_valid: every good header.
  - feature0_valid and feature1_valid: extended headers only.
  - addr_valid: a lightweight request header, or the ADDR flit.
  - data_valid: each DATA flit.

## Timing
- Every output pulse and field register update appears on the posedge after the accepting edge. Latency is 1 cycle; there is no other pipelining.
- Full throughput: one flit per cycle. Back-to-back packets need no idle flit between them.
- i_slave_rx_ready low: o_flit_ready is low in the same cycle (combinational), no flit is accepted, state is frozen, and no new pulses occur. Pulses already registered from the previous edge still appear.
- Reset, in any state:
  - State goes to IDLE and the counter to 0.
  - All outputs are 0, including o_err and all field registers.
  - o_flit_ready is 0 while rst is high.
  - A reset mid-packet abandons that packet; the first flit after reset is treated as a header.
- Simultaneous events: an invalid header in IDLE pulses o_err only; no other valid is asserted.

## Test plan
- Lightweight write: 40'hFFDD000026, then 40'hAA, then 40'hBB.
  - Required: cmd=1, length=1, addr=FFDD0000, all pulsed on the same cycle.
  - Then data 000000AA and 000000BB on consecutive cycles. No feature valids.
- Extended write: 40'h00000FC147, then 40'h888, then data 1234, 5678, 2444, 3666.
  - Required: cmd=1, length=2, feature0=01, feature1=3F on the header pulse.
  - Then addr=00000888, then 4 data pulses in order, then IDLE.
- Lightweight read request 40'hAABB000022 followed immediately by the extended write above.
  - Required: cmd=0 and addr=AABB0000 with no data pulse.
  - The next flit is decoded as a header with no gap.
- Read response: 40'h4B (extended, length 2), then 4 data flits.
  - Required: cmd=2, no addr_valid, 4 data pulses.
  - The idle flit 40'h0 before it produces no pulses.
- Error and backpressure:
  - Header 40'h1E (cmd=7): one-cycle o_err pulse, no other valids.
  - i_slave_rx_ready low for 3 cycles mid-DATA: o_flit_ready low and no data pulses; data resumes in order afterwards.
- Reset mid-packet: rst high for 1 cycle after the extended header and address.
  - Required: all outputs 0.
  - Next flit 40'hFFDD000026 decodes as a new lightweight write header.
